// File: rtl/mod_counter_monitor.sv
// Sequence monitor for a modulus-MOD counter: tracks the observed q bus,
// flags illegal values and out-of-order steps, and counts completed wraps.
module mod_counter_monitor #(
  parameter int MOD        = 6,
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WIDTH-1:0]      q,
  input  logic                  clr_err,
  output logic                  locked,
  output logic                  wrap_pulse,
  output logic                  err_pulse,
  output logic [1:0]            err_code,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WRAP_CNT_W-1:0] wrap_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] RESYNC = 2'd2;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_SEQ     = 2'b10;

  // One extra bit so MOD == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MOD - 1);

  logic [1:0]            state_q,      state_d;
  logic [WIDTH-1:0]      expected_q,   expected_d;
  logic                  wrap_pulse_q, wrap_pulse_d;
  logic                  err_pulse_q,  err_pulse_d;
  logic [1:0]            err_code_q,   err_code_d;
  logic [ERR_CNT_W-1:0]  err_count_q,  err_count_d;
  logic [WRAP_CNT_W-1:0] wrap_count_q, wrap_count_d;
  logic                  fault;
  logic [1:0]            fault_code;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    expected_d   = expected_q;
    wrap_pulse_d = 1'b0;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    fault        = 1'b0;
    fault_code   = CODE_NONE;

    if (clr_err) begin
      err_count_d = '0;
      err_code_d  = CODE_NONE;
    end

    if (en) begin
      case (state_q)
        TRACK: begin
          if ({1'b0, q} >= MOD_EXT) begin
            fault      = 1'b1;
            fault_code = CODE_ILLEGAL;
          end else if (q != expected_q) begin
            fault      = 1'b1;
            fault_code = CODE_SEQ;
          end else begin
            expected_d = (expected_q == LAST) ? '0 : expected_q + WIDTH'(1);
            if (q == LAST) begin
              wrap_pulse_d = 1'b1;
              if (wrap_count_q != '1) wrap_count_d = wrap_count_q + WRAP_CNT_W'(1);
            end
          end
        end
        default: begin
          // IDLE and RESYNC behave identically: wait silently for a zero.
          if (q == '0) begin
            state_d    = TRACK;
            expected_d = WIDTH'(1);
          end
        end
      endcase

      if (fault) begin
        state_d     = RESYNC;
        err_pulse_d = 1'b1;
        err_code_d  = fault_code;
        // A clear on the same edge discards history but still records this fault.
        if (clr_err)                 err_count_d = ERR_CNT_W'(1);
        else if (err_count_q != '1)  err_count_d = err_count_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (!rst) begin
      state_q      <= IDLE;
      expected_q   <= '0;
      wrap_pulse_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= CODE_NONE;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign locked     = (state_q == TRACK);
  assign wrap_pulse = wrap_pulse_q;
  assign err_pulse  = err_pulse_q;
  assign err_code   = err_code_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_mod_counter_monitor.sv
// Bench for mod_counter_monitor: directed scenarios plus randomized traffic,
// all outputs compared every cycle against an arithmetic reference model.
module tb_mod_counter_monitor;

  localparam int MOD        = 6;
  localparam int WIDTH      = 4;
  localparam int ERR_CNT_W  = 2;
  localparam int WRAP_CNT_W = 3;
  localparam int ERR_MAX    = (1 << ERR_CNT_W) - 1;
  localparam int WRAP_MAX   = (1 << WRAP_CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  en = 1'b0;
  logic [WIDTH-1:0]      q = '0;
  logic                  clr_err = 1'b0;
  logic                  locked;
  logic                  wrap_pulse;
  logic                  err_pulse;
  logic [1:0]            err_code;
  logic [ERR_CNT_W-1:0]  err_count;
  logic [WRAP_CNT_W-1:0] wrap_count;

  mod_counter_monitor #(
    .MOD(MOD), .WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W), .WRAP_CNT_W(WRAP_CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .q(q), .clr_err(clr_err),
    .locked(locked), .wrap_pulse(wrap_pulse), .err_pulse(err_pulse),
    .err_code(err_code), .err_count(err_count), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "locked" plus the next value we expect to see.
  bit m_locked, m_wp, m_ep;
  int m_next, m_code, m_ecnt, m_wcnt;
  bit cmp_on = 0;

  always @(posedge clk) begin
    int v;
    int fc;
    v  = int'(q);
    fc = 0;
    if (!rst) begin
      m_locked = 0; m_next = 0; m_wp = 0; m_ep = 0;
      m_code = 0; m_ecnt = 0; m_wcnt = 0;
    end else begin
      m_wp = 0;
      m_ep = 0;
      if (clr_err) begin
        m_ecnt = 0;
        m_code = 0;
      end
      if (en) begin
        if (!m_locked) begin
          if (v == 0) begin
            m_locked = 1;
            m_next   = 1 % MOD;
          end
        end else if (v >= MOD) fc = 1;
        else if (v != m_next)  fc = 2;
        else begin
          if (v == MOD - 1) begin
            m_wp   = 1;
            m_wcnt = (m_wcnt < WRAP_MAX) ? m_wcnt + 1 : WRAP_MAX;
          end
          m_next = (v + 1) % MOD;
        end
        if (fc != 0) begin
          m_ep     = 1;
          m_code   = fc;
          m_ecnt   = clr_err ? 1 : ((m_ecnt < ERR_MAX) ? m_ecnt + 1 : ERR_MAX);
          m_locked = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("locked",     32'(locked),     32'(m_locked));
      check("wrap_pulse", 32'(wrap_pulse), 32'(m_wp));
      check("err_pulse",  32'(err_pulse),  32'(m_ep));
      check("err_code",   32'(err_code),   32'(m_code));
      check("err_count",  32'(err_count),  32'(m_ecnt));
      check("wrap_count", 32'(wrap_count), 32'(m_wcnt));
    end
  end

  // Drive one cycle's inputs, let the edge happen, settle just after it.
  task automatic cyc(input bit r, input bit e, input bit c, input int qv);
    @(negedge clk);
    rst = r; en = e; clr_err = c; q = WIDTH'(qv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(0, 0, 0, 0);
    cmp_on = 1;
    cyc(0, 1, 1, 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_wcnt",   32'(wrap_count), 0);
    check("rst_ecnt",   32'(err_count), 0);

    // Two clean revolutions.
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 0, i % MOD);
      if (i == 0)         check("lock_first", 32'(locked), 1);
      if (i % MOD == 5)   check("wrap_at_5", 32'(wrap_pulse), 1);
      else                check("no_wrap", 32'(wrap_pulse), 0);
    end
    check("wcnt_2",  32'(wrap_count), 2);
    check("ecnt_0",  32'(err_count), 0);
    check("code_0",  32'(err_code), 0);

    // Illegal value, then relock.
    cyc(1, 1, 0, 7);
    check("ill_pulse", 32'(err_pulse), 1);
    check("ill_code",  32'(err_code), 1);
    check("ill_cnt",   32'(err_count), 1);
    check("ill_lock",  32'(locked), 0);
    cyc(1, 1, 0, 0);
    check("relock",     32'(locked), 1);
    check("ill_pulse1", 32'(err_pulse), 0);

    // Sequence fault on 3 after 0,1; then 4 is ignored in RESYNC.
    cyc(1, 1, 1, 1);
    check("clr_cnt", 32'(err_count), 0);
    check("clr_code", 32'(err_code), 0);
    cyc(1, 1, 0, 3);
    check("seq_code", 32'(err_code), 2);
    check("seq_cnt",  32'(err_count), 1);
    cyc(1, 1, 0, 4);
    check("resync_nopulse", 32'(err_pulse), 0);
    check("resync_unlock",  32'(locked), 0);

    // Saturate the 2-bit error counter, then clear on the edge of a fault.
    cyc(1, 1, 1, 9);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 9);
    end
    check("sat_cnt", 32'(err_count), 3);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 2);
    check("clr_fault_cnt",  32'(err_count), 1);
    check("clr_fault_code", 32'(err_code), 2);

    // Freeze with en=0 while driving garbage.
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, i);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 9);
      check("frz_lock", 32'(locked), 1);
      check("frz_ep",   32'(err_pulse), 0);
    end
    cyc(1, 1, 0, 4);
    check("unfrz_ep",   32'(err_pulse), 0);
    check("unfrz_lock", 32'(locked), 1);
    cyc(1, 1, 0, 5);
    check("unfrz_wrap", 32'(wrap_pulse), 1);

    // Mid-sequence reset.
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 1, 0, i % MOD);
    check("pre_rst_wcnt", 32'(wrap_count), 1);
    cyc(0, 1, 0, 3);
    check("mid_rst_lock", 32'(locked), 0);
    check("mid_rst_wcnt", 32'(wrap_count), 0);
    cyc(1, 1, 0, 3);
    check("post_rst_nolock", 32'(locked), 0);
    cyc(1, 1, 0, 0);
    check("post_rst_lock", 32'(locked), 1);

    // Randomized traffic, mostly well-formed so wraps saturate.
    for (int i = 0; i < 3000; i++) begin
      int qv;
      bit r, e, c;
      r  = ($urandom_range(0, 199) != 0);
      e  = ($urandom_range(0, 9) < 8);
      c  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) < 8) qv = m_locked ? m_next : 0;
      else                          qv = $urandom_range(0, (1 << WIDTH) - 1);
      cyc(r, e, c, qv);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
